// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS memory-access stage: access sizes, FSM states,
// byte-lane masks and the request context captured while a memory access is outstanding.
package mips_mem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RD_W   = 5;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   localparam logic [3:0] BE_BYTE    = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   typedef struct packed {
      logic [RD_W-1:0] rd;
      logic            reg_write;
      logic            is_load;
      logic [1:0]      size;
      logic            zext;
      logic [1:0]      addr_lo;
   } mem_ctx_t;

   // Size 2'b11 behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = addr_lo[0];
         SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
         default:   is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if #(
   parameter int unsigned DMEM_ADDR_W = 32
) ();
   logic                   req;
   logic                   we;
   logic [DMEM_ADDR_W-1:0] addr;
   logic [3:0]             be;
   logic [31:0]            wdata;
   logic                   ack;
   logic [31:0]            rdata;

   modport master (output req, we, addr, be, wdata, input ack, rdata);
   modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/replication and load extraction/extension.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        zext,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be_c,
   output logic [31:0] wdata_c,
   output logic [31:0] load_data_c
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b      = 8'(load_word >> {addr_lo, 3'b000});
      lane_h      = addr_lo[1] ? load_word[31:16] : load_word[15:0];
      be_c        = BE_WORD;
      wdata_c     = store_data;
      load_data_c = load_word;
      case (size)
         SIZE_BYTE: begin
            be_c        = BE_BYTE << addr_lo;
            wdata_c     = {4{store_data[7:0]}};
            load_data_c = zext ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
         end
         SIZE_HALF: begin
            be_c        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_c     = {2{store_data[15:0]}};
            load_data_c = zext ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM pipeline stage: issues data-memory requests, stalls upstream until acknowledged,
// and produces the writeback bundle (ALU pass-through, formatted loads, misalignment flag).
module mem_access_stage
   import mips_mem_pkg::*;
#(
   parameter int unsigned DMEM_ADDR_W = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   ex_valid,
   input  logic [DMEM_ADDR_W-1:0] ex_alu_result,
   input  logic [31:0]            ex_store_data,
   input  logic                   ex_mem_read,
   input  logic                   ex_mem_write,
   input  logic [1:0]             ex_size,
   input  logic                   ex_unsigned,
   input  logic [4:0]             ex_rd,
   input  logic                   ex_reg_write,
   mem_access_stage_if.master     dmem,
   output logic                   mem_stall,
   output logic                   wb_valid,
   output logic [31:0]            wb_data,
   output logic [4:0]             wb_rd,
   output logic                   wb_reg_write,
   output logic                   misalign_exc
);
   logic [0:0]             state_q, state_d;
   logic                   req_q, req_d, we_q, we_d;
   logic [DMEM_ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]             be_q, be_d;
   logic [31:0]            wdata_q, wdata_d;
   mem_ctx_t               ctx_q, ctx_d;
   logic                   wb_valid_d, wb_reg_write_d, exc_d, stall_d;
   logic [31:0]            wb_data_d;
   logic [4:0]             wb_rd_d;

   logic                   in_access;
   logic [3:0]             lane_be;
   logic [31:0]            lane_wdata, lane_load;

   assign in_access = (state_q == ST_ACCESS);

   // One aligner: fed from ex_* when issuing, from the captured context when completing a load.
   mem_lane_align u_align (
      .size        (in_access ? ctx_q.size    : ex_size),
      .addr_lo     (in_access ? ctx_q.addr_lo : ex_alu_result[1:0]),
      .zext        (in_access ? ctx_q.zext    : ex_unsigned),
      .store_data  (ex_store_data),
      .load_word   (dmem.rdata),
      .be_c        (lane_be),
      .wdata_c     (lane_wdata),
      .load_data_c (lane_load)
   );

   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      we_d           = we_q;
      addr_d         = addr_q;
      be_d           = be_q;
      wdata_d        = wdata_q;
      ctx_d          = ctx_q;
      wb_valid_d     = 1'b0;
      wb_data_d      = wb_data;
      wb_rd_d        = wb_rd;
      wb_reg_write_d = 1'b0;
      exc_d          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               if (!(ex_mem_read || ex_mem_write)) begin
                  wb_valid_d     = 1'b1;
                  wb_data_d      = 32'(ex_alu_result);
                  wb_rd_d        = ex_rd;
                  wb_reg_write_d = ex_reg_write;
               end else if (is_misaligned(ex_size, ex_alu_result[1:0])) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = ex_rd;
                  exc_d      = 1'b1;
               end else begin
                  state_d = ST_ACCESS;
                  req_d   = 1'b1;
                  we_d    = ex_mem_write && !ex_mem_read;
                  addr_d  = {ex_alu_result[DMEM_ADDR_W-1:2], 2'b00};
                  be_d    = lane_be;
                  wdata_d = lane_wdata;
                  ctx_d   = '{rd: ex_rd, reg_write: ex_reg_write, is_load: ex_mem_read,
                              size: ex_size, zext: ex_unsigned, addr_lo: ex_alu_result[1:0]};
               end
            end
         end
         ST_ACCESS: begin
            if (dmem.ack) begin
               state_d    = ST_IDLE;
               req_d      = 1'b0;
               we_d       = 1'b0;
               wb_valid_d = 1'b1;
               wb_rd_d    = ctx_q.rd;
               if (ctx_q.is_load) begin
                  wb_data_d      = lane_load;
                  wb_reg_write_d = ctx_q.reg_write;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      stall_d = (state_d == ST_ACCESS);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         be_q         <= 4'b0;
         wdata_q      <= 32'b0;
         ctx_q        <= '0;
         mem_stall    <= 1'b0;
         wb_valid     <= 1'b0;
         wb_data      <= 32'b0;
         wb_rd        <= 5'b0;
         wb_reg_write <= 1'b0;
         misalign_exc <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         ctx_q        <= ctx_d;
         mem_stall    <= stall_d;
         wb_valid     <= wb_valid_d;
         wb_data      <= wb_data_d;
         wb_rd        <= wb_rd_d;
         wb_reg_write <= wb_reg_write_d;
         misalign_exc <= exc_d;
      end
   end

   assign dmem.req   = req_q;
   assign dmem.we    = we_q;
   assign dmem.addr  = addr_q;
   assign dmem.be    = be_q;
   assign dmem.wdata = wdata_q;
endmodule
